// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM states,
// the dark cathode pattern and the hex-to-segment lookup table.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // All cathodes off (active-low), used for blanking and masked digits
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; element k is the glyph for nibble k
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment cathode pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Plain table lookup; every nibble value has a glyph
  always_comb begin
    seg_o = HEX_SEG[hex_i];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. Each digit slot starts with a
// blanked guard interval, then shows the digit. Display content is double
// buffered so that a new value only takes effect at a frame boundary.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N            = 3,
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [N-1:0]            sel,
  output logic                    sel_valid,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [N-1:0]  DIGIT_LAST = N'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N-1:0]            sel_q, sel_d;
  logic [4*NUM_DIGITS-1:0] actData_q, actData_d, pendData_q, pendData_d;
  logic [NUM_DIGITS-1:0]   actDp_q, actDp_d, pendDp_q, pendDp_d;
  logic [NUM_DIGITS-1:0]   actEn_q, actEn_d, pendEn_q, pendEn_d;
  logic                    pendFlag_q, pendFlag_d;
  logic                    selValid_q, selValid_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frameDone_q, frameDone_d;
  logic [3:0]              nibble;
  logic                    digitOn;
  logic                    digitDp;
  logic [6:0]              glyph;

  // Next-state for the scan FSM, slot counter and both content buffers
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    frameDone_d = 1'b0;
    actData_d   = actData_q;
    actDp_d     = actDp_q;
    actEn_d     = actEn_q;
    pendData_d  = pendData_q;
    pendDp_d    = pendDp_q;
    pendEn_d    = pendEn_q;
    pendFlag_d  = pendFlag_q;

    if (load) begin
      pendData_d = data_in;
      pendDp_d   = dp_in;
      pendEn_d   = digit_en;
      pendFlag_d = 1'b1;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sel_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_BLANK;
          cnt_d      = '0;
          sel_d      = '0;
          pendFlag_d = 1'b0;
          if (load) begin
            actData_d = data_in;
            actDp_d   = dp_in;
            actEn_d   = digit_en;
          end else begin
            actData_d = pendData_q;
            actDp_d   = pendDp_q;
            actEn_d   = pendEn_q;
          end
        end
        default: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            if (sel_q == DIGIT_LAST) begin
              sel_d       = '0;
              frameDone_d = 1'b1;
              pendFlag_d  = 1'b0;
              if (load) begin
                actData_d = data_in;
                actDp_d   = dp_in;
                actEn_d   = digit_en;
              end else if (pendFlag_q) begin
                actData_d = pendData_q;
                actDp_d   = pendDp_q;
                actEn_d   = pendEn_q;
              end
            end else begin
              sel_d = sel_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == ST_BLANK && cnt_q == BLANK_LAST) begin
              state_d = ST_SHOW;
            end
          end
        end
      endcase
    end
  end

  // Pick the nibble, mask and decimal point of the digit being entered next
  always_comb begin
    nibble  = 4'h0;
    digitOn = 1'b0;
    digitDp = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_d == N'(k)) begin
        nibble  = actData_d[4*k +: 4];
        digitOn = actEn_d[k];
        digitDp = actDp_d[k];
      end
    end
  end

  hex_to_seg uHexToSeg (
    .hex_i (nibble),
    .seg_o (glyph)
  );

  // Output values for the upcoming cycle; dark outside SHOW or when masked
  always_comb begin
    selValid_d = (state_d == ST_SHOW) && digitOn;
    seg_d      = selValid_d ? glyph : SEG_BLANK;
    dp_d       = ~(selValid_d && digitDp);
  end

  // State, counters, buffers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      actData_q   <= '0;
      actDp_q     <= '0;
      actEn_q     <= '0;
      pendData_q  <= '0;
      pendDp_q    <= '0;
      pendEn_q    <= '0;
      pendFlag_q  <= 1'b0;
      selValid_q  <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      actData_q   <= actData_d;
      actDp_q     <= actDp_d;
      actEn_q     <= actEn_d;
      pendData_q  <= pendData_d;
      pendDp_q    <= pendDp_d;
      pendEn_q    <= pendEn_d;
      pendFlag_q  <= pendFlag_d;
      selValid_q  <= selValid_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = selValid_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with 4 digits, 8-cycle
// slots and a 2-cycle blanking guard.
module tb_seg_scan_ctrl;

  localparam int N     = 2;
  localparam int ND    = 4;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;

  logic          clk;
  logic          rstN;
  logic          enable;
  logic          load;
  logic [15:0]   dataIn;
  logic [3:0]    dpIn;
  logic [3:0]    digitEn;
  logic [N-1:0]  sel;
  logic          selValid;
  logic [6:0]    seg;
  logic          dp;
  logic          frameDone;

  int checkCount;
  int errorCount;

  seg_scan_ctrl #(
    .N            (N),
    .NUM_DIGITS   (ND),
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .enable     (enable),
    .load       (load),
    .data_in    (dataIn),
    .dp_in      (dpIn),
    .digit_en   (digitEn),
    .sel        (sel),
    .sel_valid  (selValid),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frameDone)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-written active-low glyph table
  function automatic logic [6:0] glyphOf(input logic [3:0] h);
    case (h)
      4'h0: glyphOf = 7'h40;  4'h1: glyphOf = 7'h79;
      4'h2: glyphOf = 7'h24;  4'h3: glyphOf = 7'h30;
      4'h4: glyphOf = 7'h19;  4'h5: glyphOf = 7'h12;
      4'h6: glyphOf = 7'h02;  4'h7: glyphOf = 7'h78;
      4'h8: glyphOf = 7'h00;  4'h9: glyphOf = 7'h10;
      4'hA: glyphOf = 7'h08;  4'hB: glyphOf = 7'h03;
      4'hC: glyphOf = 7'h46;  4'hD: glyphOf = 7'h21;
      4'hE: glyphOf = 7'h06;  default: glyphOf = 7'h0E;
    endcase
  endfunction

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkDark(input string tag);
    checkOutput({tag, " sel"}, 32'(sel), 32'd0);
    checkOutput({tag, " sel_valid"}, 32'(selValid), 32'd0);
    checkOutput({tag, " seg"}, 32'(seg), 32'h7F);
    checkOutput({tag, " dp"}, 32'(dp), 32'd1);
    checkOutput({tag, " frame_done"}, 32'(frameDone), 32'd0);
  endtask

  // Walks nCycles of a frame starting at cycle 0 (called on a falling edge),
  // checking each cycle, and optionally pulses load after cycle loadAt
  task automatic applyStimulus(input string name, input int nCycles,
                               input logic [15:0] expData, input logic [3:0] expEn,
                               input logic [3:0] expDp, input bit fdFirst,
                               input int loadAt, input logic [15:0] ldData,
                               input logic [3:0] ldEn, input logic [3:0] ldDp);
    int         slot;
    int         phase;
    bit         lit;
    logic [6:0] expSeg;
    for (int c = 0; c < nCycles; c++) begin
      slot   = c / SLOT;
      phase  = c % SLOT;
      lit    = (phase >= BLANK) && expEn[slot];
      expSeg = lit ? glyphOf(expData[4*slot +: 4]) : 7'h7F;
      checkOutput($sformatf("%s c%0d sel", name, c), 32'(sel), 32'(slot));
      checkOutput($sformatf("%s c%0d sel_valid", name, c), 32'(selValid), 32'(lit));
      checkOutput($sformatf("%s c%0d seg", name, c), 32'(seg), 32'(expSeg));
      checkOutput($sformatf("%s c%0d dp", name, c), 32'(dp),
                  32'(!(lit && expDp[slot])));
      checkOutput($sformatf("%s c%0d frame_done", name, c), 32'(frameDone),
                  32'(c == 0 && fdFirst));
      if (c == loadAt) begin
        load    = 1'b1;
        dataIn  = ldData;
        digitEn = ldEn;
        dpIn    = ldDp;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rstN    = 1'b0;
    enable  = 1'b0;
    load    = 1'b0;
    dataIn  = 16'h0;
    dpIn    = 4'h0;
    digitEn = 4'h0;

    repeat (3) @(negedge clk);
    checkDark("reset");
    rstN = 1'b1;
    @(negedge clk);
    checkDark("idle");

    // Preload content while idle, then start scanning
    load    = 1'b1;
    dataIn  = 16'h3210;
    digitEn = 4'hF;
    dpIn    = 4'h0;
    @(negedge clk);
    load = 1'b0;
    checkDark("idle after load");
    enable = 1'b1;
    @(negedge clk);

    applyStimulus("f1", 32, 16'h3210, 4'hF, 4'h0, 1'b0, -1, 16'h0, 4'h0, 4'h0);
    applyStimulus("f2", 32, 16'h3210, 4'hF, 4'h0, 1'b1, 10, 16'hABCD, 4'hF, 4'h0);
    applyStimulus("f3", 32, 16'hABCD, 4'hF, 4'h0, 1'b1, -1, 16'h0, 4'hF, 4'h0);
    applyStimulus("f4", 32, 16'hABCD, 4'hF, 4'h0, 1'b1, 31, 16'hFFFF, 4'hF, 4'h0);
    applyStimulus("f5", 32, 16'hFFFF, 4'hF, 4'h0, 1'b1, 5, 16'h3210, 4'b0101, 4'hF);
    applyStimulus("f6", 32, 16'h3210, 4'b0101, 4'hF, 1'b1, -1, 16'h0, 4'b0101, 4'hF);

    // Drop enable during the sel=2 SHOW phase
    applyStimulus("f7", 19, 16'h3210, 4'b0101, 4'hF, 1'b1, -1, 16'h0, 4'b0101, 4'hF);
    checkOutput("drop pre sel", 32'(sel), 32'd2);
    checkOutput("drop pre seg", 32'(seg), 32'h24);
    enable = 1'b0;
    @(negedge clk);
    checkDark("enable dropped");
    @(negedge clk);
    checkDark("enable dropped +1");
    enable = 1'b1;
    @(negedge clk);
    applyStimulus("f8", 32, 16'h3210, 4'b0101, 4'hF, 1'b0, -1, 16'h0, 4'b0101, 4'hF);

    // Asynchronous reset in the middle of a SHOW phase
    applyStimulus("f9", 5, 16'h3210, 4'b0101, 4'hF, 1'b1, -1, 16'h0, 4'b0101, 4'hF);
    checkOutput("pre-reset seg", 32'(seg), 32'h40);
    checkOutput("pre-reset dp", 32'(dp), 32'd0);
    #2;
    rstN   = 1'b0;
    enable = 1'b0;
    #1;
    checkDark("async reset");
    @(negedge clk);
    rstN   = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    applyStimulus("f10", 32, 16'h0000, 4'h0, 4'h0, 1'b0, -1, 16'h0, 4'b0101, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 7-segment display bank.
- Steps through digit positions and drives the active-low anode decoder's select/enable inputs.
- Generates matching active-low cathode patterns, with a blanking guard between digits to suppress ghosting.
- Display content is double-buffered: new values apply only at frame boundaries, so a frame never shows a torn value.

Parameters:
- N, 3: digit-select width; matches the anode decoder's select width.
- NUM_DIGITS, 8: digits scanned per frame; range 2..2**N.
- SLOT_CYCLES, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000: blanked cycles at the start of each slot; range 1..SLOT_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable; low forces the display dark
- load  in  1  single-cycle strobe; captures data_in, dp_in, digit_en
- data_in  in  4*NUM_DIGITS  hex nibble per digit; digit k = bits [4k+3:4k]
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- digit_en  in  NUM_DIGITS  per-digit display mask, 1 = shown
- sel  out  N  digit index; drives the decoder `in`
- sel_valid  out  1  drives the decoder `enable`
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal-point cathode, active-low
- frame_done  out  1  one-cycle pulse per completed frame

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state=IDLE, sel=0, sel_valid=0, seg=7'h7F, dp=1, frame_done=0.
  - Active and pending buffers cleared to 0; pending flag cleared.
- Registered outputs: all outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - Outputs are dark.
  - On an edge with enable=1: active←pending (or ←inputs if load is high that edge), sel←0, cycle_cnt←0, go to BLANK.
- BLANK:
  - sel_valid=0, seg=7'h7F, dp=1.
  - After BLANK_CYCLES cycles, go to SHOW.
- SHOW:
  - sel_valid = active digit_en[sel].
  - seg = hex_to_seg(active nibble[sel]), or 7'h7F if that digit is masked.
  - dp = ~(active dp[sel] & digit_en[sel]).
  - Lasts SLOT_CYCLES-BLANK_CYCLES cycles.
  - Total slot length is exactly SLOT_CYCLES cycles.
- Slot end:
  - sel < NUM_DIGITS-1: sel←sel+1, go to BLANK.
  - sel = NUM_DIGITS-1: sel wraps to 0, frame_done=1 for one cycle (the first cycle of the next frame's digit-0 BLANK), and active←pending if the pending flag is set.
- Load:
  - The pending buffer captures inputs on any edge with load=1, and the pending flag is set.
  - Load on the frame-boundary edge: the new inputs go straight to the active buffer and the pending flag is cleared.
  - Back-to-back loads: the last one wins.
- enable deasserted in any state:
  - Next edge: IDLE, outputs dark, sel←0, counters cleared.
  - Pending buffer retained.
  - No frame_done pulse.
- Masked digits still consume a full slot, so the refresh rate stays constant.
- hex_to_seg encoding (active-low, 0=lit): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
- Counter width: cycle_cnt is $clog2(SLOT_CYCLES) bits and compares exactly. It never exceeds SLOT_CYCLES-1.

Decomposition:
- Package seg_pkg:
  - State enum (IDLE/BLANK/SHOW).
  - SEG_BLANK = 7'h7F.
  - The 16-entry hex-to-segment constant table.
- Sub-module: hex_to_seg (combinational 4→7 lookup using seg_pkg). All other logic stays in seg_scan_ctrl.

Test Plan:
Configuration for all tests: NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, N=2.
- Reset then enable=1 with data_in=16'h3210 loaded beforehand, digit_en=4'hF:
  - sel runs 0,1,2,3,0 with 8 cycles each; sel_valid low for 2 cycles then high for 6.
  - seg = 40, 79, 24, 30.
  - frame_done pulses every 32 cycles.
- Load 16'hABCD mid-frame (during sel=1 SHOW):
  - Rest of the frame still shows 3,2.
  - From the next frame, seg = 21, 46, 03, 08 for sel 0..3.
- Load asserted exactly on the frame-boundary edge with 16'hFFFF: the digit-0 SHOW of the new frame shows 0E.
- digit_en=4'b0101, dp_in=4'hF:
  - Slots 1 and 3 keep sel_valid=0, seg=7F, dp=1 for all 8 cycles.
  - Slots 0 and 2 show dp=0.
- enable dropped during the sel=2 SHOW:
  - Next cycle: sel=0, sel_valid=0, seg=7F, no frame_done.
  - Re-enable restarts at digit 0 in BLANK.
- rst_n asserted asynchronously mid-SHOW: outputs go to reset values immediately, without a clock edge; buffers are cleared.
